// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state type for the SPI slave register block
package spi_pkg;

    localparam int         CMD_RD_BIT     = 7;
    localparam int         BYTE_W         = 8;
    localparam logic [6:0] ABORT_CNT_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-flop pin synchronizers with SCLK/CSN edge detect and aligned MOSI
module spi_pin_sync
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_rise,
    output logic csn_fall,
    output logic mosi
);

    // bit 0 and bit 1 form the synchronizer, bit 2 is the history stage for edge detect
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] csn_sync_q,  csn_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        csn_sync_d  = {csn_sync_q[1:0],  spi_csn};
        mosi_sync_d = {mosi_sync_q[0],   spi_mosi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            csn_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
    assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
    // MOSI sits at the same depth as the SCLK edge detect so it is sampled aligned
    assign mosi      = mosi_sync_q[1];

endmodule

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI mode-0 slave with byte register file; SPI_SLAVE_ABORT_CNT_EN adds abort counter
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              wr_valid,
    output logic [AW-1:0]     wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     host_addr,
    output logic [BYTE_W-1:0] host_rdata
`ifdef SPI_SLAVE_ABORT_CNT_EN
    ,
    output logic [7:0]        abort_cnt
`endif
);

    logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi;

    spi_pin_sync u_pin_sync (
        .clk       (sclk),
        .rst_n     (rst_n),
        .spi_sclk  (SPI_SCLK),
        .spi_csn   (SPI_CSN),
        .spi_mosi  (SPI_MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_rise  (csn_rise),
        .csn_fall  (csn_fall),
        .mosi      (mosi)
    );

    spi_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0] shift_in_q, shift_in_d;
    logic [BYTE_W-1:0] shift_out_q, shift_out_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              miso_q, miso_d;
    logic              wr_valid_q, wr_valid_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic [BYTE_W-1:0] host_rdata_q, host_rdata_d;
    logic [BYTE_W-1:0] regs_q [DEPTH];
    logic [BYTE_W-1:0] regs_d [DEPTH];

    logic [BYTE_W-1:0] new_byte;
    logic [AW-1:0]     cmd_addr;
    logic [AW-1:0]     addr_inc;
    logic [BYTE_W-1:0] rd_first;

    assign new_byte = {shift_in_q, mosi};
    assign cmd_addr = new_byte[AW-1:0];
    assign addr_inc = addr_q + 1'b1;

`ifdef SPI_SLAVE_ABORT_CNT_EN
    logic [7:0] abort_cnt_q, abort_cnt_d;

    // the counter only replaces the first byte of a read at the command address
    assign rd_first  = (new_byte[6:0] == ABORT_CNT_ADDR) ? abort_cnt_q : regs_q[cmd_addr];
    assign abort_cnt = abort_cnt_q;
`else
    assign rd_first  = regs_q[cmd_addr];
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        addr_d       = addr_q;
        miso_d       = miso_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        regs_d       = regs_q;
        host_rdata_d = regs_q[host_addr];
`ifdef SPI_SLAVE_ABORT_CNT_EN
        abort_cnt_d  = abort_cnt_q;
`endif

        if (state_q != IDLE && csn_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
`ifdef SPI_SLAVE_ABORT_CNT_EN
            if (bit_cnt_q != 3'd0 && abort_cnt_q != 8'hFF) begin
                abort_cnt_d = abort_cnt_q + 8'd1;
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    if (csn_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = new_byte[BYTE_W-2:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = cmd_addr;
                            if (new_byte[CMD_RD_BIT]) begin
                                state_d     = RDATA;
                                shift_out_d = rd_first;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_in_d = new_byte[BYTE_W-2:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            regs_d[addr_q] = new_byte;
                            wr_valid_d     = 1'b1;
                            wr_addr_d      = addr_q;
                            wr_data_d      = new_byte;
                            addr_d         = addr_inc;
                        end
                    end
                end
                RDATA: begin
                    // every fall presents the current MSB; the byte reload happens on the 8th rise
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d      = addr_inc;
                            shift_out_d = regs_q[addr_inc];
                        end
                    end else if (sclk_fall) begin
                        miso_d      = shift_out_q[BYTE_W-1];
                        shift_out_d = {shift_out_q[BYTE_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            addr_q       <= '0;
            miso_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            host_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            addr_q       <= addr_d;
            miso_q       <= miso_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
            regs_q       <= regs_d;
        end
    end

`ifdef SPI_SLAVE_ABORT_CNT_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt_q <= '0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end
`endif

    assign SPI_MISO   = miso_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI Mode-0 slave that sits directly downstream of SPI_Master, on the far end of its SPI_SCLK/SPI_CSN/SPI_MOSI/SPI_MISO bus.
- Oversamples the SPI pins on the system clock and decodes a command byte followed by a burst of data bytes.
- Reads and writes an internal byte register file with address auto-increment.
- Serves as the bus-functional target for SPI_Master benches and as the on-chip SPI register block.

Parameters:
- DEPTH, 16, number of 8-bit registers; must be a power of 2, from 2 to 128.
- AW, $clog2(DEPTH), register address width; derived, do not override.

Ports:
- sclk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SPI_SCLK  input  1  SPI clock from master; CPOL=0.
- SPI_CSN  input  1  chip select, active low.
- SPI_MOSI  input  1  master-to-slave data, MSB first.
- SPI_MISO  output  1  slave-to-master data, MSB first.
- wr_valid  output  1  one-cycle pulse when an SPI write commits a register.
- wr_addr  output  AW  address of the committed write.
- wr_data  output  8  data of the committed write.
- host_addr  input  AW  local read address.
- host_rdata  output  8  regfile[host_addr], registered, 1-cycle latency.

Behaviour:
- Reset: SPI_MISO=0, wr_valid=0, wr_addr=0, wr_data=0, host_rdata=0, all registers=0x00, FSM=IDLE.
- Reset mid-frame aborts the frame immediately; nothing is committed.
- Pin sync: SPI_SCLK, SPI_CSN and SPI_MOSI each pass through 2 flops; edges are detected from the 2nd and 3rd flop stages.
- Detect latency: 3 sclk cycles from pin edge to detect.
- Requirement on the master: SPI_SCLK high and low phases each ≥4 sclk cycles, i.e. SPI_Master sclk_divider ≥ 4.
- Frame format:
  - Byte 0 is the command. Bit7 = R/W (1 = read). Bits6:0 = start address; only the low AW bits are used, so higher addresses alias modulo DEPTH.
  - Bytes 1..N are data.
- Bit timing: MOSI is sampled on each detected SCLK rise. MISO changes only on a detected SCLK fall, or on CSN assertion.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE: on CSN fall go to CMD; clear the bit counter; SPI_MISO=0.
  - CMD: shift in 8 bits. On the 8th rise, latch the address and go to WDATA or RDATA. For a read, also load shift_out=regfile[addr] on that same cycle. SPI_MISO=0 throughout the command byte.
  - RDATA:
    - On the 8th fall of the command byte, drive shift_out[7].
    - Each subsequent fall shifts out the next bit.
    - On each 8th rise, addr=addr+1 mod DEPTH and reload shift_out=regfile[addr]; its MSB is driven on the next fall.
    - Data bytes on MOSI are ignored.
  - WDATA:
    - On each 8th rise: regfile[addr]<=byte; wr_valid=1 for exactly 1 cycle, with wr_addr/wr_data holding the committed values; then addr=addr+1 mod DEPTH.
    - SPI_MISO=0.
  - Any state, CSN rise: go to IDLE, SPI_MISO=0. A partial byte (1–7 bits) is discarded with no write and no wr_valid. The address is not retained across frames.
- Wrap-around: a burst past DEPTH-1 continues at 0.
- SCLK edges while CSN is high are ignored.
- host_rdata: registered; host_rdata<=regfile[host_addr] every cycle.
- Simultaneous host read and SPI commit to the same address: host_rdata returns the old value that cycle and the new value the following cycle.
- wr_addr/wr_data hold their last values between pulses.

Optional Feature:
- Macro: SPI_SLAVE_ABORT_CNT_EN.
- When defined:
  - An 8-bit saturating counter (saturates at 0xFF) increments on every CSN rise that lands with 1–7 bits of a byte received.
  - It resets to 0.
  - It is readable over SPI at command address 0x7F, which overrides the regfile alias for that byte only. Auto-increment then proceeds normally.
  - Writes to 0x7F still go to the regfile alias.
  - An extra output port abort_cnt (8 bits) is present.
- When undefined: no counter, no abort_cnt port, and 0x7F aliases like any other address.

Decomposition:
- Shared package spi_pkg:
  - CMD_RD_BIT=7, BYTE_W=8, ABORT_CNT_ADDR=7'h7F.
  - FSM state typedef {IDLE, CMD, WDATA, RDATA}.
- One sub-module, spi_pin_sync: 2-flop synchronizer plus rise/fall edge detect for SCLK and CSN, and MOSI alignment.
- The regfile stays inline.

Test Plan:
- Write burst: command 0x03, data 0x11 0x22 0x33 with sclk_divider=4 -> regs[3..5]=11,22,33; wr_valid pulses 3 times with wr_addr 3,4,5; host_addr=4 reads 0x22 one cycle later.
- Read burst: preload regs[14]=0xAA, regs[15]=0xBB, regs[0]=0xCC; command 0x8E, 3 dummy bytes -> master receives 0x00 during the command byte, then AA, BB, CC (wrap verified).
- Abort: command 0x02, then CSN rises after 5 data bits -> regs[2] unchanged, no wr_valid. With SPI_SLAVE_ABORT_CNT_EN, abort_cnt goes 0->1; a read at 0x7F returns 0x01.
- Reset mid-frame: rst_n low during the 2nd data bit of a write -> all outputs 0, regs 0x00. The next frame, command 0x81 then 1 byte, returns 0x00.
- Alias and collision: command 0x12 (DEPTH=16 → address 2) writes 0x5A, with host_addr=2 during the commit cycle -> host_rdata=old value, then 0x5A.
- Minimum speed: sclk_divider=4 with alternating 0x55/0xAA round-trip write then read -> all bytes match, no bit slips.
